// File: rtl/irda_sir_rx_pkg.sv
// -----------------------------------------------------------------------------
// irda_pkg
// Shared declarations for the IrDA SIR receive path.
//   rx_state_e : receiver FSM states
//   ENTRY_W    : width of one buffered character {break, parity_err, frame_err, data[7:0]}
//   bit_cycles : clock cycles per bit, rounded to the nearest integer
// -----------------------------------------------------------------------------
package irda_pkg;

  localparam int ENTRY_W = 11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  // Rounded division so that e.g. 1843200 / 115200 gives exactly 16.
  function automatic int bit_cycles(input int clk, input int baud);
    return (clk + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/irda_sir_rx_if.sv
// -----------------------------------------------------------------------------
// irda_sir_rx_if
// Bundles the IR input and the character stream output of irda_sir_rx.
//   i_ir            : raw IR receiver output (asynchronous)
//   o_data          : head character, LSB-aligned
//   o_frame_err     : head character stop bit was 0
//   o_parity_err    : head character parity mismatch
//   o_break         : head character is a break (zero data + frame error)
//   o_valid/i_ready : FIFO head handshake, pop on o_valid & i_ready
//   o_overrun       : sticky, a character was dropped on a full FIFO
//   i_clear_overrun : clears o_overrun
//   o_busy          : receiver is inside a frame
// slave is the receiver side, master is the consumer/driver side.
// -----------------------------------------------------------------------------
interface irda_sir_rx_if;

  logic       i_ir;
  logic [7:0] o_data;
  logic       o_frame_err;
  logic       o_parity_err;
  logic       o_break;
  logic       o_valid;
  logic       i_ready;
  logic       o_overrun;
  logic       i_clear_overrun;
  logic       o_busy;

  modport slave (
    input  i_ir,
    input  i_ready,
    input  i_clear_overrun,
    output o_data,
    output o_frame_err,
    output o_parity_err,
    output o_break,
    output o_valid,
    output o_overrun,
    output o_busy
  );

  modport master (
    output i_ir,
    output i_ready,
    output i_clear_overrun,
    input  o_data,
    input  o_frame_err,
    input  o_parity_err,
    input  o_break,
    input  o_valid,
    input  o_overrun,
    input  o_busy
  );

endinterface

// File: rtl/irda_sir_rx_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO shared by the IrDA receive and transmit blocks.
//   clk_i, rst_i : clock, synchronous active-high reset (empties the FIFO)
//   push_i       : write wdata_i; ignored when full unless a pop happens too
//   wdata_i      : write data
//   pop_i        : remove head; ignored when empty
//   rdata_o      : head word (FWFT=1) or last popped word (FWFT=0)
//   full_o       : DEPTH words stored
//   empty_o      : no words stored
// -----------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter bit FWFT  = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_badDepth
    $error("sync_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wrPtr_q;
  logic [AW:0]      rdPtr_q;
  logic             doPush;
  logic             doPop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty_o = (wrPtr_q == rdPtr_q);
  assign full_o  = (wrPtr_q[AW] != rdPtr_q[AW]) &&
                   (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);

  // A pop frees the head slot on the same edge, so push on full is accepted then.
  assign doPop  = pop_i && !empty_o;
  assign doPush = push_i && (!full_o || doPop);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
      if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (doPush) mem_q[wrPtr_q[AW-1:0]] <= wdata_i;
  end

  if (FWFT) begin : g_fwft
    assign rdata_o = mem_q[rdPtr_q[AW-1:0]];
  end else begin : g_registered
    logic [WIDTH-1:0] rdata_q;
    always_ff @(posedge clk_i) begin
      if (rst_i)      rdata_q <= '0;
      else if (doPop) rdata_q <= mem_q[rdPtr_q[AW-1:0]];
    end
    assign rdata_o = rdata_q;
  end

endmodule

// File: rtl/irda_sir_rx.sv
// -----------------------------------------------------------------------------
// irda_sir_rx
// IrDA SIR receiver: demodulates 3/16 bit-width IR pulses into UART characters
// and buffers them in a FWFT FIFO.
//   i_clk : sole clock
//   i_rst : synchronous active-high reset (aborts any frame, empties FIFO)
//   bus   : irda_sir_rx_if.slave, IR input plus character/flag/handshake outputs
// A qualified pulse inside a bit period means 0, no pulse means 1. Every pulse
// re-aligns the bit timer so that slow clock drift is absorbed per bit.
// -----------------------------------------------------------------------------
module irda_sir_rx
  import irda_pkg::*;
#(
  parameter int CLK_FREQ      = 1843200,
  parameter int BAUD          = 115200,
  parameter int DATA_BITS     = 8,
  parameter bit PARITY_EN     = 1'b0,
  parameter bit PARITY_EVEN   = 1'b0,
  parameter bit IR_ACTIVE_LOW = 1'b1,
  parameter int MIN_PULSE_CYC = 2,
  parameter int FIFO_DEPTH    = 4
) (
  input logic          i_clk,
  input logic          i_rst,
  irda_sir_rx_if.slave bus
);

  localparam int BIT_CYC = bit_cycles(CLK_FREQ, BAUD);
  localparam int HALF    = BIT_CYC / 2;
  localparam int CNT_W   = $clog2(BIT_CYC);
  localparam int QW      = $clog2(MIN_PULSE_CYC + 1);

  localparam logic [2:0] ST_IDLE   = IDLE;
  localparam logic [2:0] ST_START  = START;
  localparam logic [2:0] ST_DATA   = DATA;
  localparam logic [2:0] ST_PARITY = PARITY;
  localparam logic [2:0] ST_STOP   = STOP;

  if (BIT_CYC < 8) begin : g_badBitCyc
    $error("irda_sir_rx: BIT_CYC must be at least 8");
  end
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_badDataBits
    $error("irda_sir_rx: DATA_BITS must be 5..8");
  end
  if (MIN_PULSE_CYC < 1 || MIN_PULSE_CYC > BIT_CYC / 4) begin : g_badMinPulse
    $error("irda_sir_rx: MIN_PULSE_CYC must be 1..BIT_CYC/4");
  end

  logic [1:0]         irSync_q;
  logic               irActive;
  logic [QW-1:0]      pulseCnt_q, pulseCnt_d;
  logic               qpulse;
  logic [2:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               seen_q, seen_d;
  logic [2:0]         bitIdx_q, bitIdx_d;
  logic [7:0]         data_q, data_d;
  logic               parityErr_q, parityErr_d;
  logic               overrun_q, overrun_d;
  logic               decide;
  logic               bitVal;
  logic               expParity;
  logic               frameErr;
  logic               breakFlag;
  logic               push;
  logic [ENTRY_W-1:0] pushEntry;
  logic [ENTRY_W-1:0] fifoHead;
  logic [ENTRY_W-1:0] headEntry;
  logic               fifoFull;
  logic               fifoEmpty;
  logic               fifoPop;

  // Two-flop synchroniser; resets to the idle line level so reset never
  // looks like the leading edge of a pulse.
  always_ff @(posedge i_clk) begin
    if (i_rst) irSync_q <= IR_ACTIVE_LOW ? 2'b11 : 2'b00;
    else       irSync_q <= {irSync_q[0], bus.i_ir};
  end

  assign irActive = IR_ACTIVE_LOW ? ~irSync_q[1] : irSync_q[1];

  // Saturating run-length count of active cycles; the strobe fires only on the
  // cycle the count reaches MIN_PULSE_CYC, so long pulses give one strobe.
  always_comb begin
    pulseCnt_d = '0;
    qpulse     = 1'b0;
    if (irActive) begin
      if (pulseCnt_q != QW'(MIN_PULSE_CYC)) pulseCnt_d = pulseCnt_q + 1'b1;
      else                                  pulseCnt_d = pulseCnt_q;
      qpulse = (pulseCnt_q == QW'(MIN_PULSE_CYC - 1));
    end
  end

  // A realigning pulse wins over a decision in the same cycle; the bit it
  // marks is then decided half a period later with seen already set.
  assign decide    = (state_q != ST_IDLE) && !qpulse && (cnt_q == CNT_W'(HALF));
  assign bitVal    = ~seen_q;
  assign expParity = PARITY_EVEN ? ^data_q : ~^data_q;
  assign frameErr  = ~bitVal;
  assign breakFlag = frameErr && (data_q == 8'h00);
  assign pushEntry = {breakFlag, parityErr_q, frameErr, data_q};

  // Bit timer, pulse memory and frame FSM.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    seen_d      = seen_q;
    bitIdx_d    = bitIdx_q;
    data_d      = data_q;
    parityErr_d = parityErr_q;
    push        = 1'b0;

    if (state_q == ST_IDLE) begin
      cnt_d  = '0;
      seen_d = 1'b0;
      if (qpulse) begin
        state_d     = ST_START;
        bitIdx_d    = '0;
        data_d      = '0;
        parityErr_d = 1'b0;
      end
    end else begin
      if (qpulse) begin
        cnt_d  = '0;
        seen_d = 1'b1;
      end else begin
        cnt_d = (cnt_q == CNT_W'(BIT_CYC - 1)) ? '0 : cnt_q + 1'b1;
        if (decide) seen_d = 1'b0;
      end

      case (state_q)
        ST_START: begin
          if (decide) begin
            state_d  = ST_DATA;
            bitIdx_d = '0;
          end
        end
        ST_DATA: begin
          if (decide) begin
            data_d[bitIdx_q] = bitVal;
            if (bitIdx_q == 3'(DATA_BITS - 1)) state_d = PARITY_EN ? ST_PARITY : ST_STOP;
            else                               bitIdx_d = bitIdx_q + 1'b1;
          end
        end
        ST_PARITY: begin
          if (decide) begin
            parityErr_d = (bitVal != expParity);
            state_d     = ST_STOP;
          end
        end
        ST_STOP: begin
          if (decide) begin
            push    = 1'b1;
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pulseCnt_q  <= '0;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      seen_q      <= 1'b0;
      bitIdx_q    <= '0;
      data_q      <= '0;
      parityErr_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      pulseCnt_q  <= pulseCnt_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      seen_q      <= seen_d;
      bitIdx_q    <= bitIdx_d;
      data_q      <= data_d;
      parityErr_q <= parityErr_d;
      overrun_q   <= overrun_d;
    end
  end

  // A new overrun takes priority over a clear in the same cycle.
  assign fifoPop = !fifoEmpty && bus.i_ready;

  always_comb begin
    overrun_d = overrun_q;
    if (push && fifoFull && !fifoPop) overrun_d = 1'b1;
    else if (bus.i_clear_overrun)     overrun_d = 1'b0;
  end

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH),
    .FWFT  (1'b1)
  ) u_fifo (
    .clk_i   (i_clk),
    .rst_i   (i_rst),
    .push_i  (push),
    .wdata_i (pushEntry),
    .pop_i   (fifoPop),
    .rdata_o (fifoHead),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );

  // FIFO storage is not reset, so the head is masked while empty.
  assign headEntry        = fifoEmpty ? '0 : fifoHead;
  assign bus.o_data       = headEntry[7:0];
  assign bus.o_frame_err  = headEntry[8];
  assign bus.o_parity_err = headEntry[9];
  assign bus.o_break      = headEntry[10];
  assign bus.o_valid      = !fifoEmpty;
  assign bus.o_overrun    = overrun_q;
  assign bus.o_busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_irda_sir_rx.sv
// -----------------------------------------------------------------------------
// tb_irda_sir_rx
// Self-checking bench for irda_sir_rx. dutA is 8N1, dutB is 8E1; both run at
// 16 clocks per bit with active-low IR pulses. Expected characters are queued
// when a frame is sent; per-DUT monitors pop and compare on every handshake.
// -----------------------------------------------------------------------------
module tb_irda_sir_rx;
  import irda_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  irda_sir_rx_if ifA ();
  irda_sir_rx_if ifB ();

  irda_sir_rx #(
    .CLK_FREQ(1843200), .BAUD(115200), .DATA_BITS(8), .PARITY_EN(1'b0),
    .PARITY_EVEN(1'b0), .IR_ACTIVE_LOW(1'b1), .MIN_PULSE_CYC(2), .FIFO_DEPTH(4)
  ) dutA (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (ifA.slave)
  );

  irda_sir_rx #(
    .CLK_FREQ(1843200), .BAUD(115200), .DATA_BITS(8), .PARITY_EN(1'b1),
    .PARITY_EVEN(1'b1), .IR_ACTIVE_LOW(1'b1), .MIN_PULSE_CYC(2), .FIFO_DEPTH(4)
  ) dutB (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (ifB.slave)
  );

  logic [ENTRY_W-1:0] expA[$];
  logic [ENTRY_W-1:0] expB[$];
  logic [ENTRY_W-1:0] gotA, wantA, gotB, wantB;
  int   riseCycA = -1;
  logic prevValidA = 1'b0;
  logic busySeenA = 1'b0;

  // Scoreboard monitor for dutA: every accepted head is compared in order.
  always @(negedge clk) begin
    if (!rst && ifA.o_valid && ifA.i_ready) begin
      gotA = {ifA.o_break, ifA.o_parity_err, ifA.o_frame_err, ifA.o_data};
      checks++;
      if (expA.size() == 0) begin
        errors++;
        $display("[TB] FAIL popA_unexpected: got entry %h, required no character", gotA);
      end else begin
        wantA = expA.pop_front();
        if (gotA !== wantA) begin
          errors++;
          $display("[TB] FAIL popA: got brk/par/frm=%b data=%h, required brk/par/frm=%b data=%h",
                   gotA[10:8], gotA[7:0], wantA[10:8], wantA[7:0]);
        end
      end
    end
  end

  // Scoreboard monitor for dutB.
  always @(negedge clk) begin
    if (!rst && ifB.o_valid && ifB.i_ready) begin
      gotB = {ifB.o_break, ifB.o_parity_err, ifB.o_frame_err, ifB.o_data};
      checks++;
      if (expB.size() == 0) begin
        errors++;
        $display("[TB] FAIL popB_unexpected: got entry %h, required no character", gotB);
      end else begin
        wantB = expB.pop_front();
        if (gotB !== wantB) begin
          errors++;
          $display("[TB] FAIL popB: got brk/par/frm=%b data=%h, required brk/par/frm=%b data=%h",
                   gotB[10:8], gotB[7:0], wantB[10:8], wantB[7:0]);
        end
      end
    end
  end

  // Observers for o_valid rise timing and o_busy activity on dutA.
  always @(negedge clk) begin
    if (ifA.o_valid && !prevValidA) riseCycA = cyc;
    prevValidA = ifA.o_valid;
    if (ifA.o_busy) busySeenA = 1'b1;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %0d (0x%h), required %0d (0x%h)", name, got, got, want, want);
    end
  endtask

  task automatic setIr(input int which, input logic level);
    if (which == 0) ifA.i_ir = level;
    else            ifB.i_ir = level;
  endtask

  task automatic expectChar(input int which, input logic brk, input logic par,
                            input logic frm, input logic [7:0] d);
    if (which == 0) expA.push_back({brk, par, frm, d});
    else            expB.push_back({brk, par, frm, d});
  endtask

  // Drives one frame of 16-tick slots: a pulse marks a 0 bit. Pulse n is
  // delayed by drift*n ticks; maxTicks > 0 truncates the frame.
  task automatic applyStimulus(input int which, input logic [7:0] data, input bit hasPar,
                               input bit parBit, input bit stopPulse, input int drift,
                               input int pulseLen, input int maxTicks, output int startCyc);
    bit slotPulse[12];
    int starts[12];
    int nSlots;
    int np;
    int total;
    bit act;
    nSlots = 10 + (hasPar ? 1 : 0);
    slotPulse[0] = 1'b1;
    for (int i = 0; i < 8; i++) slotPulse[i + 1] = ~data[i];
    if (hasPar) slotPulse[9] = ~parBit;
    slotPulse[nSlots - 1] = stopPulse;
    np = 0;
    for (int s = 0; s < nSlots; s++) begin
      if (slotPulse[s]) begin
        starts[np] = 16 * s + drift * np;
        np++;
      end
    end
    total = nSlots * 16 + drift * np;
    if (maxTicks > 0 && maxTicks < total) total = maxTicks;
    startCyc = 0;
    for (int t = 0; t < total; t++) begin
      @(posedge clk);
      #1;
      if (t == 0) startCyc = cyc;
      act = 1'b0;
      for (int j = 0; j < np; j++)
        if (t >= starts[j] && t < starts[j] + pulseLen) act = 1'b1;
      setIr(which, ~act);
    end
    @(posedge clk);
    #1;
    setIr(which, 1'b1);
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 3000 && (expA.size() != 0 || expB.size() != 0); i++) @(negedge clk);
    checkOutput("drainA", expA.size(), 0);
    checkOutput("drainB", expB.size(), 0);
  endtask

  int c0;

  initial begin
    rst = 1'b1;
    ifA.i_ir = 1'b1; ifA.i_ready = 1'b1; ifA.i_clear_overrun = 1'b0;
    ifB.i_ir = 1'b1; ifB.i_ready = 1'b1; ifB.i_clear_overrun = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rstData",      ifA.o_data, 0);
    checkOutput("rstFrameErr",  ifA.o_frame_err, 0);
    checkOutput("rstParityErr", ifA.o_parity_err, 0);
    checkOutput("rstBreak",     ifA.o_break, 0);
    checkOutput("rstValid",     ifA.o_valid, 0);
    checkOutput("rstOverrun",   ifA.o_overrun, 0);
    checkOutput("rstBusy",      ifA.o_busy, 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (4) @(posedge clk);

    // 8N1 0x55: start at tick 0, stop decision 156 cycles later, o_valid the cycle after.
    expectChar(0, 1'b0, 1'b0, 1'b0, 8'h55);
    applyStimulus(0, 8'h55, 1'b0, 1'b0, 1'b0, 0, 3, 0, c0);
    checkOutput("validRiseCycle", riseCycA, c0 + 157);
    waitDrain();

    // 1-cycle glitches are rejected by the qualifier.
    busySeenA = 1'b0;
    for (int g = 0; g < 10; g++) begin
      @(posedge clk); #1 setIr(0, 1'b0);
      repeat (4) begin @(posedge clk); #1 setIr(0, 1'b1); end
    end
    repeat (20) @(posedge clk);
    @(negedge clk);
    checkOutput("glitchBusy",  busySeenA, 0);
    checkOutput("glitchValid", ifA.o_valid, 0);

    // A lone 2-cycle pulse qualifies and starts a frame of all ones.
    busySeenA = 1'b0;
    expectChar(0, 1'b0, 1'b0, 1'b0, 8'hFF);
    applyStimulus(0, 8'hFF, 1'b0, 1'b0, 1'b0, 0, 2, 0, c0);
    checkOutput("shortPulseBusy", busySeenA, 1);
    waitDrain();

    // Cumulative +3 cycle drift per pulse, absorbed by re-alignment.
    expectChar(0, 1'b0, 1'b0, 1'b0, 8'hA3);
    applyStimulus(0, 8'hA3, 1'b0, 1'b0, 1'b0, 3, 3, 0, c0);
    // Break on the 8N1 receiver: zero data with a pulsed stop slot.
    expectChar(0, 1'b1, 1'b0, 1'b1, 8'h00);
    applyStimulus(0, 8'h00, 1'b0, 1'b0, 1'b1, 0, 3, 0, c0);
    waitDrain();

    // 8E1: 0x07 needs parity 1; sending 0 flags a parity error.
    expectChar(1, 1'b0, 1'b1, 1'b0, 8'h07);
    applyStimulus(1, 8'h07, 1'b1, 1'b0, 1'b0, 0, 3, 0, c0);
    expectChar(1, 1'b0, 1'b0, 1'b1, 8'h07);
    applyStimulus(1, 8'h07, 1'b1, 1'b1, 1'b1, 0, 3, 0, c0);
    expectChar(1, 1'b1, 1'b0, 1'b1, 8'h00);
    applyStimulus(1, 8'h00, 1'b1, 1'b0, 1'b1, 0, 3, 0, c0);
    expectChar(1, 1'b0, 1'b0, 1'b0, 8'h5A);
    applyStimulus(1, 8'h5A, 1'b1, 1'b0, 1'b0, 0, 3, 0, c0);
    waitDrain();

    // Back-to-back frames into a stalled FIFO: the 5th character is dropped.
    @(posedge clk); #1 ifA.i_ready = 1'b0;
    expectChar(0, 1'b0, 1'b0, 1'b0, 8'h11);
    applyStimulus(0, 8'h11, 1'b0, 1'b0, 1'b0, 0, 3, 0, c0);
    expectChar(0, 1'b0, 1'b0, 1'b0, 8'h22);
    applyStimulus(0, 8'h22, 1'b0, 1'b0, 1'b0, 0, 3, 0, c0);
    expectChar(0, 1'b0, 1'b0, 1'b0, 8'h33);
    applyStimulus(0, 8'h33, 1'b0, 1'b0, 1'b0, 0, 3, 0, c0);
    expectChar(0, 1'b0, 1'b0, 1'b0, 8'h44);
    applyStimulus(0, 8'h44, 1'b0, 1'b0, 1'b0, 0, 3, 0, c0);
    @(negedge clk);
    checkOutput("noOverrunAtFull", ifA.o_overrun, 0);
    applyStimulus(0, 8'h99, 1'b0, 1'b0, 1'b0, 0, 3, 0, c0);
    @(negedge clk);
    checkOutput("overrunSet", ifA.o_overrun, 1);
    checkOutput("validWhileFull", ifA.o_valid, 1);
    checkOutput("headWhileFull", ifA.o_data, 8'h11);
    @(posedge clk); #1 ifA.i_clear_overrun = 1'b1;
    @(posedge clk); #1 ifA.i_clear_overrun = 1'b0;
    @(negedge clk);
    checkOutput("overrunCleared", ifA.o_overrun, 0);
    @(posedge clk); #1 ifA.i_ready = 1'b1;
    waitDrain();
    @(negedge clk);
    checkOutput("emptyAfterPops", ifA.o_valid, 0);

    // Reset mid-DATA discards the partial frame; the next frame is clean.
    applyStimulus(0, 8'h3C, 1'b0, 1'b0, 1'b0, 0, 3, 88, c0);
    @(negedge clk);
    checkOutput("busyMidFrame", ifA.o_busy, 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("busyInReset",  ifA.o_busy, 0);
    checkOutput("validInReset", ifA.o_valid, 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    expectChar(0, 1'b0, 1'b0, 1'b0, 8'h3C);
    applyStimulus(0, 8'h3C, 1'b0, 1'b0, 1'b0, 0, 3, 0, c0);
    waitDrain();
    repeat (20) @(posedge clk);
    @(negedge clk);
    checkOutput("finalValid", ifA.o_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
